bram_arbiter: RTL
=================

BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the BRAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning the BRAM data width.
REQ-003 SHALL have port clock  input  1  single clock for all logic; BRAM clka/clkb SHALL be driven from this clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports reqN_valid  input  1  request from requester N (N=0,1).
REQ-006 SHALL have ports reqN_ready  output  1  request N accepted this cycle.
REQ-007 SHALL have ports reqN_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports reqN_addr  input  ADDR_W  byte address.
REQ-009 SHALL have ports reqN_wdata  input  DATA_W  write data.
REQ-010 SHALL have ports respN_valid  output  1  read data valid for requester N.
REQ-011 SHALL have ports respN_rdata  output  DATA_W  read data.
REQ-012 SHALL have ports bram_ena, bram_wea  output  1  write-port enable and write strobe.
REQ-013 SHALL have ports bram_addra  output  ADDR_W  and bram_dina  output  DATA_W  write-port address and data.
REQ-014 SHALL have ports bram_enb  output  1  and bram_addrb  output  ADDR_W  read-port enable and address.
REQ-015 SHALL have port bram_doutb  input  DATA_W  registered read data, 1-cycle latency.

Function
REQ-016 SHALL arbitrate the write port and the read port independently; one write and one read SHALL be granted per cycle.
REQ-017 SHALL compute reqN_ready combinationally from the current valids and arbitration state.
REQ-018 SHALL treat a request as accepted iff reqN_valid && reqN_ready; an unaccepted request SHALL hold its fields stable until accepted.
REQ-019 SHALL drive bram_ena = bram_wea = 1 with addra/dina from the winning writer in the cycle of acceptance, and 0 otherwise.
REQ-020 SHALL drive bram_enb = 1 with addrb from the winning reader in the cycle of acceptance, and 0 otherwise.
REQ-021 SHALL assert respN_valid exactly one cycle after a read accept for requester N, with respN_rdata = bram_doutb, for one cycle.
REQ-022 SHALL hold respN_rdata at its last value while respN_valid = 0; responses SHALL NOT be back-pressured.
REQ-023 SHALL track the read owner in a registered 1-bit tag plus a pending bit; back-to-back reads every cycle SHALL be supported.
REQ-024 SHALL grant an uncontested request immediately.
REQ-025 SHALL grant a same-type contest (both read or both write) by arbitration policy (REQ-035/036) and hold the loser's ready at 0.
REQ-026 SHALL grant both requesters in the same cycle when one reads and the other writes.
REQ-027 SHALL NOT forward data on a same-cycle read and write to the same address; the read SHALL return the pre-write contents.

Reset
REQ-028 SHALL, while reset = 1, force reqN_ready = 0, bram_ena = bram_wea = bram_enb = 0.
REQ-029 SHALL clear respN_valid and the pending bit on reset; the cycle after reset SHALL NOT produce a response.
REQ-030 SHALL drop a read accepted in the cycle before reset asserts; its response SHALL NOT appear.
REQ-031 SHALL reset respN_rdata to 0 and both priority pointers to requester 0.

Configuration
REQ-032 SHALL honour the macro BRAM_ARB_RR_EN.
REQ-033 With BRAM_ARB_RR_EN defined, each port SHALL have a 1-bit round-robin pointer.
REQ-034 With BRAM_ARB_RR_EN defined, each pointer SHALL point to the non-winner after every contested grant and SHALL be unchanged after an uncontested grant.
REQ-035 With BRAM_ARB_RR_EN defined, a contest SHALL be won by the requester the pointer selects.
REQ-036 Without BRAM_ARB_RR_EN, requester 0 SHALL always win contests and no pointer registers SHALL exist.

Verification
REQ-037 SHALL cover: req0 write addr 0x123 data 0xA5 -> bram_ena=bram_wea=1, addra=0x123, dina=0xA5 same cycle; then req1 read 0x123 -> resp1_valid next cycle, rdata 0xA5.
REQ-038 SHALL cover: req0 read 0x010 and req1 write 0x020 same cycle -> both ready=1, enb and ena both 1.
REQ-039 SHALL cover, with BRAM_ARB_RR_EN: both requesters read continuously for 4 cycles -> grants alternate 0,1,0,1 and resp0/resp1 alternate one cycle later.
REQ-040 SHALL cover, without BRAM_ARB_RR_EN: both requesters read continuously -> req1_ready stays 0 until req0_valid drops.
REQ-041 SHALL cover: write 0x55 then same-cycle write 0x66 and read of addr 0x7FF -> read returns 0x55; a following read returns 0x66.
REQ-042 SHALL cover: read accepted at cycle T, reset=1 at T+1 -> resp0_valid=resp1_valid=0 at T+1 and T+2; all enables 0 during reset.

Source files
------------

// File: rtl/bram_arbiter.sv
// Two-requester arbiter in front of a simple dual-port BRAM (write port A, read port B).
// Define BRAM_ARB_RR_EN for per-port round-robin arbitration; default is fixed priority to req0.
module bram_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,

    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [DATA_W-1:0] bram_dina,
    output logic              bram_enb,
    output logic [ADDR_W-1:0] bram_addrb,
    input  logic [DATA_W-1:0] bram_doutb
);

    logic w0, w1, r0, r1;
    logic wr_pick1, rd_pick1;
    logic wr_go, rd_go;

    assign w0 = req0_valid & req0_we;
    assign w1 = req1_valid & req1_we;
    assign r0 = req0_valid & ~req0_we;
    assign r1 = req1_valid & ~req1_we;

`ifdef BRAM_ARB_RR_EN
    // Pointer value is the requester that wins the next contest on that port.
    logic wr_ptr_q, rd_ptr_q;

    assign wr_pick1 = w1 & (~w0 | wr_ptr_q);
    assign rd_pick1 = r1 & (~r0 | rd_ptr_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (w0 && w1) wr_ptr_q <= ~wr_pick1;
            if (r0 && r1) rd_ptr_q <= ~rd_pick1;
        end
    end
`else
    assign wr_pick1 = w1 & ~w0;
    assign rd_pick1 = r1 & ~r0;
`endif

    assign wr_go = ~reset & (w0 | w1);
    assign rd_go = ~reset & (r0 | r1);

    assign req0_ready = ~reset & ((w0 & ~wr_pick1) | (r0 & ~rd_pick1));
    assign req1_ready = ~reset & ((w1 & wr_pick1) | (r1 & rd_pick1));

    always_comb begin
        bram_ena   = wr_go;
        bram_wea   = wr_go;
        bram_addra = '0;
        bram_dina  = '0;
        if (wr_go) begin
            bram_addra = wr_pick1 ? req1_addr  : req0_addr;
            bram_dina  = wr_pick1 ? req1_wdata : req0_wdata;
        end
    end

    always_comb begin
        bram_enb   = rd_go;
        bram_addrb = '0;
        if (rd_go) bram_addrb = rd_pick1 ? req1_addr : req0_addr;
    end

    // Read owner tracking: pending marks a read in flight, tag names its requester.
    logic              rd_pend_q, rd_tag_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pend_q <= 1'b0;
            rd_tag_q  <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rd_pend_q <= rd_go;
            if (rd_go)       rd_tag_q <= rd_pick1;
            if (resp0_valid) rdata0_q <= bram_doutb;
            if (resp1_valid) rdata1_q <= bram_doutb;
        end
    end

    // Gating with reset drops a read accepted just before reset asserts.
    assign resp0_valid = ~reset & rd_pend_q & ~rd_tag_q;
    assign resp1_valid = ~reset & rd_pend_q &  rd_tag_q;
    assign resp0_rdata = resp0_valid ? bram_doutb : rdata0_q;
    assign resp1_rdata = resp1_valid ? bram_doutb : rdata1_q;

endmodule
